// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the programmable clock divider.
// The high time of an N-cycle period is ceil(N/2), so odd ratios spend the extra cycle high.
package clk_div_pkg;

  localparam int C_WIDTH_DEFAULT = 8;

  function automatic logic [31:0] half_hi(input logic [31:0] n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/clk_div.sv
// clk_div: programmable integer divider producing a registered square wave of div_rate cycles.
// Optional feature macro CLK_DIV_TICK_EN adds a one-cycle tick pulse on each clk_out rise.
module clk_div
  import clk_div_pkg::*;
#(
  parameter int C_WIDTH = C_WIDTH_DEFAULT
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic [C_WIDTH-1:0] div_rate,
`ifdef CLK_DIV_TICK_EN
  output logic               tick,
`endif
  output logic               clk_out
);

  logic [C_WIDTH-1:0] cnt;
  logic [C_WIDTH-1:0] n_q;
  logic [C_WIDTH-1:0] high_len;
  logic               enabled;
  logic               period_end;

  always_comb begin
    high_len   = C_WIDTH'(half_hi(32'(n_q)));
    enabled    = (n_q > C_WIDTH'(1));
    period_end = (cnt == n_q - C_WIDTH'(1));
  end

  // Counter and output register: the ratio is only re-sampled at a period boundary
  // (or continuously while disabled), so a rate change never distorts a running period.
  always_ff @(posedge clk_in) begin
    if (reset || !enabled) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      n_q     <= div_rate;
    end else begin
      clk_out <= (cnt < high_len);
      if (period_end) begin
        cnt <= '0;
        n_q <= div_rate;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef CLK_DIV_TICK_EN
  // Tick fires on the edge that issues cnt == 0, i.e. together with the clk_out rise.
  always_ff @(posedge clk_in) begin
    if (reset || !enabled) begin
      tick <= 1'b0;
    end else begin
      tick <= (cnt == '0);
    end
  end
`endif

endmodule

// File: tb/tb_clk_div.sv
// tb_clk_div: randomized and directed checks of clk_div against a period-queue reference model.
// Builds with or without CLK_DIV_TICK_EN; tick is checked only when the macro is defined.
module tb_clk_div;

  logic       clk;
  logic       reset;
  logic [7:0] div_rate;
  logic       clk_out;
  logic [7:0] rate_b;
  logic [7:0] rate_c;
  logic       clk_out_b;
  logic       clk_out_c;
`ifdef CLK_DIV_TICK_EN
  logic       tick;
  logic       tick_b;
  logic       tick_c;
`endif

  int checks = 0;
  int fails  = 0;

  // Reference model: one period is expanded into a queue of output bits.
  bit m_q[$];
  int m_rate = 0;
  bit m_out  = 0;
  bit m_tick = 0;

  clk_div #(.C_WIDTH(8)) dut (
    .clk_in(clk), .reset(reset), .div_rate(div_rate),
`ifdef CLK_DIV_TICK_EN
    .tick(tick),
`endif
    .clk_out(clk_out)
  );

  clk_div #(.C_WIDTH(8)) dut_b (
    .clk_in(clk), .reset(reset), .div_rate(rate_b),
`ifdef CLK_DIV_TICK_EN
    .tick(tick_b),
`endif
    .clk_out(clk_out_b)
  );

  clk_div #(.C_WIDTH(8)) dut_c (
    .clk_in(clk), .reset(reset), .div_rate(rate_c),
`ifdef CLK_DIV_TICK_EN
    .tick(tick_c),
`endif
    .clk_out(clk_out_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_update(input bit r, input int d);
    int h;
    if (r) begin
      m_q.delete();
      m_rate = d;
      m_out  = 0;
      m_tick = 0;
    end else if (m_rate < 2) begin
      m_out  = 0;
      m_tick = 0;
      m_rate = d;
    end else begin
      m_tick = 0;
      if (m_q.size() == 0) begin
        h = m_rate - m_rate / 2;
        for (int i = 0; i < m_rate; i++) m_q.push_back(i < h);
        m_tick = 1;
      end
      m_out = m_q.pop_front();
      if (m_q.size() == 0) m_rate = d;
    end
  endtask

  task automatic step(input bit r, input int d);
    @(negedge clk);
    reset    = r;
    div_rate = 8'(d);
    @(posedge clk);
    model_update(r, d);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 2);
      checks++;
      if (clk_out !== 1'b0 || clk_out_b !== 1'b0 || clk_out_c !== 1'b0) begin
        fails++;
        $display("FAIL reset_out: got %b%b%b want 000", clk_out, clk_out_b, clk_out_c);
      end
`ifdef CLK_DIV_TICK_EN
      checks++;
      if (tick !== 1'b0) begin
        fails++;
        $display("FAIL reset_tick: got %b want 0", tick);
      end
`endif
    end
  endtask

  task automatic test_fixed_rates();
    int rates[5] = '{2, 4, 10, 3, 255};
    int n, highs, rises, ticks;
    bit prev;
    for (int r = 0; r < 5; r++) begin
      n = rates[r];
      step(1, n);
      highs = 0; rises = 0; ticks = 0; prev = 0;
      for (int k = 0; k < 3 * n; k++) begin
        step(0, n);
        checks++;
        if (clk_out !== m_out) begin
          fails++;
          $display("FAIL rate%0d_cycle%0d: got %b want %b", n, k, clk_out, m_out);
        end
        if (clk_out === 1'b1) highs++;
        if (clk_out === 1'b1 && !prev) rises++;
        prev = (clk_out === 1'b1);
`ifdef CLK_DIV_TICK_EN
        if (tick === 1'b1) ticks++;
`endif
      end
      checks++;
      if (highs != 3 * ((n + 1) / 2)) begin
        fails++;
        $display("FAIL rate%0d_high_time: got %0d want %0d", n, highs, 3 * ((n + 1) / 2));
      end
      checks++;
      if (rises != 3) begin
        fails++;
        $display("FAIL rate%0d_periods: got %0d rises want 3", n, rises);
      end
`ifdef CLK_DIV_TICK_EN
      checks++;
      if (ticks != 3) begin
        fails++;
        $display("FAIL rate%0d_ticks: got %0d want 3", n, ticks);
      end
`endif
    end
  endtask

  task automatic test_common_rise();
    bit ea, eb, ec;
    step(1, 2);
    for (int k = 0; k < 20; k++) begin
      step(0, 2);
      ea = (k % 2) < 1;
      eb = (k % 4) < 2;
      ec = (k % 10) < 5;
      checks++;
      if (clk_out !== ea || clk_out_b !== eb || clk_out_c !== ec) begin
        fails++;
        $display("FAIL common_edge%0d: got %b%b%b want %b%b%b",
                 k, clk_out, clk_out_b, clk_out_c, ea, eb, ec);
      end
    end
  endtask

  task automatic test_rate_change();
    bit exp_seq[12] = '{1, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    step(1, 4);
    step(0, 4);
    checks++;
    if (clk_out !== 1'b1) begin
      fails++;
      $display("FAIL change_first: got %b want 1", clk_out);
    end
    for (int k = 0; k < 12; k++) begin
      step(0, 6);
      checks++;
      if (clk_out !== exp_seq[k]) begin
        fails++;
        $display("FAIL change_cycle%0d: got %b want %b", k, clk_out, exp_seq[k]);
      end
    end
  endtask

  task automatic test_disabled();
    step(1, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, (k < 4) ? 0 : 1);
      checks++;
      if (clk_out !== 1'b0) begin
        fails++;
        $display("FAIL disabled_cycle%0d: got %b want 0", k, clk_out);
      end
    end
    for (int k = 0; k < 6; k++) begin
      step(0, 2);
      checks++;
      if (clk_out !== m_out) begin
        fails++;
        $display("FAIL enable_cycle%0d: got %b want %b", k, clk_out, m_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 8);
    step(0, 8);
    step(0, 8);
    step(1, 8);
    checks++;
    if (clk_out !== 1'b0) begin
      fails++;
      $display("FAIL midreset_force: got %b want 0", clk_out);
    end
    for (int k = 0; k < 8; k++) begin
      step(0, 8);
      checks++;
      if (clk_out !== (k < 4)) begin
        fails++;
        $display("FAIL midreset_restart%0d: got %b want %b", k, clk_out, k < 4);
      end
    end
  endtask

  task automatic test_random();
    int d;
    bit r;
    d = 5;
    step(1, d);
    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) d = $urandom_range(0, 12);
      step(r, d);
      checks++;
      if (clk_out !== m_out) begin
        fails++;
        $display("FAIL random_cycle%0d: got %b want %b (rate %0d)", k, clk_out, m_out, d);
      end
`ifdef CLK_DIV_TICK_EN
      checks++;
      if (tick !== m_tick) begin
        fails++;
        $display("FAIL random_tick%0d: got %b want %b", k, tick, m_tick);
      end
`endif
    end
  endtask

  initial begin
    reset    = 1'b1;
    div_rate = 8'd2;
    rate_b   = 8'd4;
    rate_c   = 8'd10;
    test_reset();
    test_fixed_rates();
    test_common_rise();
    test_rate_change();
    test_disabled();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
